// File: rtl/vgpr_wr_port_arbiter.sv
// vgpr_wr_port_arbiter: 9-way round-robin VGPR write-port arbiter with registered one-hot select
module vgpr_wr_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  req,
  input  logic        stall,
  output logic [15:0] wr_port_select,
  output logic [8:0]  gnt,
  output logic [3:0]  last_port,
  output logic [15:0] gnt_count
);
  logic [3:0] ptr;
  logic [8:0] elig;
  logic       found;
  logic [3:0] win;
  logic [4:0] sum;
  logic [3:0] idx;
  assign gnt = wr_port_select[8:0];
  // Pick the first eligible port scanning from ptr with wrap at 9; the port just granted sits out one cycle
  always_comb begin
    elig = req & ~gnt;
    found = 1'b0;
    win = 4'd0;
    sum = 5'd0;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      sum = {1'b0, ptr} + 5'(i);
      idx = (sum >= 5'd9) ? 4'(sum - 5'd9) : sum[3:0];
      if (elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // Register the grant and advance pointer, last winner and grant count; idle or stalled cycles hold state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_port_select <= 16'h0000;
      ptr <= 4'd0;
      last_port <= 4'd0;
      gnt_count <= 16'h0000;
    end else if (!stall && found) begin
      wr_port_select <= 16'(1) << win;
      ptr <= (win == 4'd8) ? 4'd0 : win + 4'd1;
      last_port <= win;
      gnt_count <= gnt_count + 16'd1;
    end else begin
      wr_port_select <= 16'h0000;
    end
  end
endmodule

// File: doc/vgpr_wr_port_arbiter.md
VGPR_WR_PORT_ARBITER -- requirements
Module: vgpr_wr_port_arbiter

Interface
REQ-001 Port clk input 1: single clock; all state updates on rising edge.
REQ-002 Port rst input 1: reset, asynchronous, active-low (0 = reset asserted).
REQ-003 Port req input 9: per-write-port request; bits 0-7 are wavefront write sources 0-7, bit 8 is the non-wavefront write source.
REQ-004 Port stall input 1: 1 = suppress new grants this cycle.
REQ-005 Port wr_port_select output 16: registered write-port select, one-hot or all-zero; bits 15:9 always 0.
REQ-006 Port gnt output 9: grant, identical to wr_port_select[8:0].
REQ-007 Port last_port output 4: index (0-8) of most recent granted port, registered.
REQ-008 Port gnt_count output 16: count of grants issued since reset, registered.

Function
REQ-009 Arbitration SHALL evaluate once per rising edge; the result SHALL appear on wr_port_select/gnt in the following cycle (1-cycle latency, registered, no combinational input-to-output path).
REQ-010 Eligible set SHALL be req & ~gnt: a port granted in the current cycle SHALL NOT be granted in the next cycle.
REQ-011 Winner SHALL be the first eligible port scanning ptr, ptr+1, ..., wrapping 8 -> 0 (9-entry round-robin); ptr is internal, 4 bits, range 0-8.
REQ-012 On a grant, ptr SHALL load winner+1, with winner 8 loading 0.
REQ-013 With no eligible port, or stall=1, wr_port_select SHALL be 16'h0000 next cycle and ptr, last_port, gnt_count SHALL hold.
REQ-014 stall SHALL take priority over any req; a request pending during stall SHALL be considered on the first edge with stall=0.
REQ-015 wr_port_select SHALL never have more than one bit set.
REQ-016 Requester handshake: requester holds req until it samples its gnt bit high, then may drop req at that edge; arbiter SHALL not require req to fall.
REQ-017 A req bit dropped before grant SHALL be treated as withdrawn; no state is kept per request.
REQ-018 On a grant, last_port SHALL load winner index and gnt_count SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-019 Simultaneous requests from all 9 ports held continuously SHALL be granted in strict rotation from ptr, every port exactly once per 9 grants.
REQ-020 A sole continuous requester SHALL be granted every other cycle (grant, idle, grant, ...) per REQ-010.
REQ-021 Fairness: any port holding req with stall=0 SHALL be granted within 9 edges.

Reset
REQ-022 rst=0 SHALL immediately, without clock, force wr_port_select=16'h0000, gnt=9'h000, last_port=0, gnt_count=0, ptr=0.
REQ-023 Reset asserted mid-operation SHALL abandon the in-flight grant; after deassertion the first grant SHALL follow REQ-011 from ptr=0.
REQ-024 First arbitration SHALL occur on the first rising edge with rst=1.

Verification
REQ-025 Reset then req=9'h1FF held, stall=0 -> wr_port_select sequence 0001,0002,0004,...,0100,0001; gnt_count=9 after 9 grants.
REQ-026 Only req[3] held for 6 edges from reset -> wr_port_select 0008,0000,0008,0000,0008,0000; last_port=3, gnt_count=3.
REQ-027 req=9'h1FF, stall=1 for 4 edges after port 2 granted -> wr_port_select 0000 during stall, next grant port 3, gnt_count unchanged during stall.
REQ-028 ptr at 8 (port 7 just granted), req=9'h101 -> grant port 8 (0100) then port 0 (0001).
REQ-029 rst pulsed low asynchronously mid-cycle while wr_port_select=0020 -> outputs zero immediately, before next edge; after release, req=9'h1FF grants port 0 first.
REQ-030 gnt_count preloaded near wrap via 65535 grants -> next grant yields gnt_count=0; one-hot checker never fires throughout.
